// File: rtl/psg_pkg.sv
// Shared types and defaults for the PSG bus writer and its command FIFO.
package psg_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT_HI, RECOVER} psg_wr_state_e;
  localparam int PSG_DIV_DEFAULT     = 28;
  localparam int PSG_TIMEOUT_DEFAULT = 64;
endpackage

// File: rtl/psg_cmd_fifo.sv
// Synchronous command FIFO with an occupancy count; full/empty derive from the registered count.
module psg_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
endmodule

// File: rtl/psg_bus_writer.sv
// Drains buffered PSG command bytes through the nCE/nWE/D write handshake, paced by the
// divided PSG clock and the synchronised READY line.
module psg_bus_writer
  import psg_pkg::*;
#(
  parameter int PSG_DIV    = PSG_DIV_DEFAULT,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = PSG_TIMEOUT_DEFAULT
) (
  input  logic                          CLK100MHZ,
  input  logic                          CPU_RESETN,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          psg_clk,
  output logic                          psg_nCE,
  output logic                          psg_nWE,
  output logic [7:0]                    psg_D,
  input  logic                          psg_READY,
  output logic                          busy,
  output logic                          err_timeout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int DIV_W  = $clog2(PSG_DIV);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic              psg_clk_q, psg_clk_d;
  logic              rdy_meta_q, rdy_s_q;
  psg_wr_state_e     state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              strobe_q, strobe_d;
  logic [7:0]        d_q, d_d;
  logic              err_q, err_d;
  logic              tick, pop, push, fifo_full, fifo_empty;
  logic [7:0]        fifo_head;

  assign tick     = psg_clk_q;
  assign push     = wr_valid & ~fifo_full;
  assign wr_ready = ~fifo_full;

  psg_cmd_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (CLK100MHZ),
    .rst_ni  (CPU_RESETN),
    .push_i  (push),
    .data_i  (wr_data),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    div_d     = (div_q == DIV_W'(PSG_DIV - 1)) ? '0 : div_q + DIV_W'(1);
    psg_clk_d = (div_q == DIV_W'(PSG_DIV - 1));
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    d_d     = d_q;
    err_d   = err_q;
    pop     = 1'b0;
    if (tick && tcnt_q != TCNT_W'(TIMEOUT)) tcnt_d = tcnt_q + TCNT_W'(1);
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            d_d     = fifo_head;
            state_d = SETUP;
          end
        end
        SETUP:   state_d = STROBE;
        STROBE: begin
          if (!rdy_s_q) begin
            state_d = WAIT_HI;
          end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = RECOVER;
          end
        end
        WAIT_HI: begin
          if (rdy_s_q) begin
            state_d = RECOVER;
          end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = RECOVER;
          end
        end
        RECOVER: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    if (state_d != state_q) tcnt_d = '0;
    // Strobe is registered from the next state so nCE/nWE never glitch on decode.
    strobe_d = (state_d == STROBE) || (state_d == WAIT_HI);
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      div_q      <= '0;
      psg_clk_q  <= 1'b0;
      rdy_meta_q <= 1'b1;
      rdy_s_q    <= 1'b1;
      state_q    <= IDLE;
      tcnt_q     <= '0;
      strobe_q   <= 1'b0;
      d_q        <= '0;
      err_q      <= 1'b0;
    end else begin
      div_q      <= div_d;
      psg_clk_q  <= psg_clk_d;
      rdy_meta_q <= psg_READY;
      rdy_s_q    <= rdy_meta_q;
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      strobe_q   <= strobe_d;
      d_q        <= d_d;
      err_q      <= err_d;
    end
  end

  assign psg_clk     = psg_clk_q;
  assign psg_nCE     = ~strobe_q;
  assign psg_nWE     = ~strobe_q;
  assign psg_D       = d_q;
  assign err_timeout = err_q;
  assign busy        = (state_q != IDLE) || (fifo_count != '0);
endmodule
